// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: slice width, FSM state type and
// an index-width helper for the serial subtractor.
package arith_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a slice counter, never narrower than one bit.
    function automatic int idx_w(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports: x_i, y_i addends; c0_i carry-in; s_o sum; c4_o carry-out.
module cla_slice4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       c0_i,
    output logic [3:0] s_o,
    output logic       c4_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = x_i & y_i;
    assign p = x_i ^ y_i;

    assign c1 = g[0]
              | (p[0] & c0_i);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0_i);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0_i);
    assign c4_o = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0_i);

    assign s_o = p ^ {c3, c2, c1, c0_i};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = a - b - bin, one 4-bit slice per clock.
// Ports: clk, rst, start/a/b/bin in; busy, done, diff, bout, zero, ovf out.
module nibble_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = idx_w(NSLICE);
    localparam int BW     = IW + 2;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] work_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;
    logic             ovf_q;

    logic [BW-1:0]    base;
    logic [3:0]       x_s;
    logic [3:0]       y_s;
    logic [3:0]       s_s;
    logic             c4_s;
    logic [WIDTH-1:0] work_d;

    // Bit offset of the active slice (index times four).
    assign base = {idx_q, 2'b00};
    assign x_s  = a_q[base +: SLICE_W];
    // Subtraction as a + ~b + carry, carry seeded with ~bin.
    assign y_s  = ~b_q[base +: SLICE_W];

    cla_slice4 u_slice (
        .x_i  (x_s),
        .y_i  (y_s),
        .c0_i (carry_q),
        .s_o  (s_s),
        .c4_o (c4_s)
    );

    always_comb begin
        work_d = work_q;
        work_d[base +: SLICE_W] = s_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ~bin;
                        idx_q   <= '0;
                        work_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= c4_s;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        diff_q  <= work_d;
                        // No carry out of the top means a borrow.
                        bout_q  <= ~c4_s;
                        zero_q  <= (work_d == '0);
                        ovf_q   <= (a_q[MSB] != b_q[MSB])
                                && (work_d[MSB] != a_q[MSB]);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule
